// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the Ethernet receive framer.
// Also hosts the CRC and preamble constants used by the TX side.
package eth_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA,
        DROP
    } rx_state_e;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    localparam logic [7:0] PRE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;

    localparam int STAT_ADDR = 0;
    localparam int STAT_CRC  = 1;
    localparam int STAT_LEN  = 2;

    // Byte idx of a MAC address in wire order (idx 0 = bits 47:40).
    function automatic logic [7:0] mac_byte(logic [47:0] mac,
                                            logic [2:0]  idx);
        logic [47:0] sh;
        sh = mac << {idx, 3'b000};
        return sh[47:40];
    endfunction

endpackage

// File: rtl/eth_rx_frame_if.sv
// Framed receive byte stream towards the packet buffer.
// No backpressure: the slave takes one byte per clock.
interface eth_rx_frame_if;
    import eth_rx_pkg::*;

    logic [7:0]  data;
    logic        vl;
    logic        sop;
    logic        eop;
    logic [2:0]  status;
    logic [10:0] len;

    modport master (
        output data, vl, sop, eop, status, len
    );

    modport slave (
        input data, vl, sop, eop, status, len
    );

endinterface

// File: rtl/eth_crc32_d8.sv
// One-byte step of the reflected Ethernet CRC-32, LSB first.
// Purely combinational; shared with the TX framer.
module eth_crc32_d8
    import eth_rx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (crc_out[0] ^ data[i])
                crc_out = (crc_out >> 1) ^ CRC_POLY;
            else
                crc_out = crc_out >> 1;
        end
    end

endmodule

// File: rtl/eth_rx_frame.sv
// RX framer: strips preamble/SFD, checks FCS, filters DA and
// enforces length limits, emitting a SOP/EOP byte stream.
module eth_rx_frame
    import eth_rx_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic           i_rx_clk,
    input  logic           rst_n,
    input  logic           i_rx_dv,
    input  logic [7:0]     i_rx_data,
    input  logic [47:0]    i_mac_addr,
    input  logic           i_promisc,
    eth_rx_frame_if.master rx_out,
    output logic [15:0]    o_good_cnt,
    output logic [15:0]    o_bad_cnt
);

    rx_state_e   state;
    logic [31:0] crc;
    logic [31:0] crc_nxt;
    logic [10:0] len;
    logic [7:0]  hold;
    logic        hold_vl;
    logic        hold_sop;
    logic        da_sta;
    logic        da_bc;
    logic        ovf;
    logic        fin;
    logic [2:0]  status;

    eth_crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (i_rx_data),
        .crc_out (crc_nxt)
    );

    // Frame verdict from the registers as they stand at EOP time.
    always_comb begin
        ovf = (state == DATA) && i_rx_dv
            && (len == 11'(MAX_LEN));
        fin = (state == DATA) && hold_vl && (!i_rx_dv || ovf);
        status = '0;
        status[STAT_LEN]  = ovf || (len < 11'(MIN_LEN));
        status[STAT_CRC]  = (crc != CRC_RESIDUE);
        status[STAT_ADDR] = (len < 11'd6)
                         || (!(da_sta || da_bc) && !i_promisc);
    end

    always_ff @(posedge i_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            crc           <= CRC_INIT;
            len           <= '0;
            hold          <= '0;
            hold_vl       <= 1'b0;
            hold_sop      <= 1'b0;
            da_sta        <= 1'b0;
            da_bc         <= 1'b0;
            rx_out.data   <= '0;
            rx_out.vl     <= 1'b0;
            rx_out.sop    <= 1'b0;
            rx_out.eop    <= 1'b0;
            rx_out.status <= '0;
            rx_out.len    <= '0;
            o_good_cnt    <= '0;
            o_bad_cnt     <= '0;
        end else begin
            rx_out.data   <= '0;
            rx_out.vl     <= 1'b0;
            rx_out.sop    <= 1'b0;
            rx_out.eop    <= 1'b0;
            rx_out.status <= '0;
            rx_out.len    <= '0;

            unique case (state)
                IDLE: begin
                    if (i_rx_dv)
                        state <= (i_rx_data == PRE_BYTE) ? PRE : DROP;
                end
                PRE: begin
                    if (!i_rx_dv) begin
                        state <= IDLE;
                    end else if (i_rx_data == SFD_BYTE) begin
                        state   <= DATA;
                        crc     <= CRC_INIT;
                        len     <= '0;
                        hold_vl <= 1'b0;
                        da_sta  <= 1'b1;
                        da_bc   <= 1'b1;
                    end else if (i_rx_data != PRE_BYTE) begin
                        state <= DROP;
                    end
                end
                DATA: begin
                    if (hold_vl) begin
                        rx_out.data <= hold;
                        rx_out.vl   <= 1'b1;
                        rx_out.sop  <= hold_sop;
                    end
                    if (fin) begin
                        rx_out.eop    <= 1'b1;
                        rx_out.status <= status;
                        rx_out.len    <= len;
                        if (status == 3'd0)
                            o_good_cnt <= o_good_cnt + 16'd1;
                        else
                            o_bad_cnt <= o_bad_cnt + 16'd1;
                    end
                    if (!i_rx_dv) begin
                        state   <= IDLE;
                        hold_vl <= 1'b0;
                    end else if (ovf) begin
                        state   <= DROP;
                        hold_vl <= 1'b0;
                    end else begin
                        crc      <= crc_nxt;
                        len      <= len + 11'd1;
                        hold     <= i_rx_data;
                        hold_vl  <= 1'b1;
                        hold_sop <= (len == 11'd0);
                        if (len < 11'd6) begin
                            da_sta <= da_sta && (i_rx_data
                                == mac_byte(i_mac_addr, len[2:0]));
                            da_bc  <= da_bc && (i_rx_data == 8'hFF);
                        end
                    end
                end
                DROP: begin
                    if (!i_rx_dv)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_rx_frame.sv
// Randomized bench for eth_rx_frame with a frame-level reference model.
// Expected streams come from a table-driven CRC and the frame rules.
module tb_eth_rx_frame;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [7:0]  data;
        logic        sop;
        logic        eop;
        logic [2:0]  status;
        logic [10:0] len;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dv = 1'b0;
    logic [7:0]  rxd = 8'h00;
    logic [47:0] mac = 48'h0A1B2C3D4E5F;
    logic        promisc = 1'b0;
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;

    eth_rx_frame_if rx_out ();

    eth_rx_frame #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .i_rx_clk   (clk),
        .rst_n      (rst_n),
        .i_rx_dv    (dv),
        .i_rx_data  (rxd),
        .i_mac_addr (mac),
        .i_promisc  (promisc),
        .rx_out     (rx_out),
        .o_good_cnt (good_cnt),
        .o_bad_cnt  (bad_cnt)
    );

    always #4 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int exp_good = 0;
    int exp_bad = 0;
    rec_t got_q[$];
    rec_t exp_q[$];
    rec_t mon_r;
    logic [31:0] crc_tab [256];

    always @(negedge clk) begin
        if (rx_out.vl) begin
            mon_r.data   = rx_out.data;
            mon_r.sop    = rx_out.sop;
            mon_r.eop    = rx_out.eop;
            mon_r.status = rx_out.status;
            mon_r.len    = rx_out.eop ? rx_out.len : 11'd0;
            got_q.push_back(mon_r);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void build_tab();
        logic [31:0] c;
        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[i] = c;
        end
    endfunction

    function automatic logic [31:0] fcs_of(input bq_t b, input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++)
            c = crc_tab[c[7:0] ^ b[i]] ^ (c >> 8);
        return ~c;
    endfunction

    task automatic make_frame(output bq_t b, input logic [47:0] da,
                              input int n, input bit corrupt);
        logic [31:0] f;
        b = {};
        for (int i = 0; i < 6; i++) b.push_back(da[47-8*i -: 8]);
        while (b.size() < n - 4) b.push_back(8'($urandom));
        f = fcs_of(b, b.size());
        for (int i = 0; i < 4; i++) b.push_back(f[8*i +: 8]);
        if (corrupt) b[20] = b[20] ^ 8'h08;
    endtask

    // Reference: what a frame of these bytes must look like at the output.
    function automatic void expect_frame(input bq_t b);
        int n;
        int no;
        logic [2:0] st;
        logic [47:0] da;
        logic [31:0] f;
        rec_t r;
        n = b.size();
        no = (n > MAX_LEN) ? MAX_LEN : n;
        if (no == 0) return;
        st = 3'd0;
        st[2] = (no < MIN_LEN) || (n > MAX_LEN);
        if (no < 4) begin
            st[1] = 1'b1;
        end else begin
            f = fcs_of(b, no - 4);
            st[1] = (f != {b[no-1], b[no-2], b[no-3], b[no-4]});
        end
        if (no < 6) begin
            st[0] = 1'b1;
        end else begin
            da = {b[0], b[1], b[2], b[3], b[4], b[5]};
            st[0] = !(da == mac || da == 48'hFFFFFFFFFFFF || promisc);
        end
        for (int i = 0; i < no; i++) begin
            r.data   = b[i];
            r.sop    = (i == 0);
            r.eop    = (i == no - 1);
            r.status = (i == no - 1) ? st : 3'd0;
            r.len    = (i == no - 1) ? 11'(no) : 11'd0;
            exp_q.push_back(r);
        end
        if (st == 3'd0) exp_good++;
        else exp_bad++;
    endfunction

    function automatic int stream_diff(output rec_t g, output rec_t e);
        g = '0;
        e = '0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) begin
                g = got_q[i];
                e = exp_q[i];
                return i;
            end
        if (got_q.size() != exp_q.size()) return -2;
        return -1;
    endfunction

    task automatic drive(input logic [7:0] d);
        @(negedge clk);
        dv = 1'b1;
        rxd = d;
    endtask

    task automatic send(input bq_t b, input int npre, input int gap);
        for (int i = 0; i < npre; i++) drive(8'h55);
        drive(8'hD5);
        foreach (b[i]) drive(b[i]);
        @(negedge clk);
        dv = 1'b0;
        rxd = 8'h00;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic settle();
        dv = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic flush();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({rx_out.vl, rx_out.sop, rx_out.eop, rx_out.status,
             rx_out.len, rx_out.data} !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got vl=%b sop=%b eop=%b st=%b len=%0d data=%h want all 0",
                     rx_out.vl, rx_out.sop, rx_out.eop, rx_out.status,
                     rx_out.len, rx_out.data);
        end
        n_checks++;
        if ({good_cnt, bad_cnt} !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got %0d/%0d want 0/0",
                     good_cnt, bad_cnt);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_good_frame();
        bq_t b;
        rec_t g, e;
        int d;
        make_frame(b, mac, 64, 1'b0);
        expect_frame(b);
        send(b, 7, 1);
        settle();
        n_checks++;
        if (got_q.size() !== 64) begin
            n_fail++;
            $display("FAIL good_frame_count: got %0d bytes want 64",
                     got_q.size());
        end
        d = stream_diff(g, e);
        n_checks++;
        if (d !== -1) begin
            n_fail++;
            $display("FAIL good_frame_stream: idx %0d got %h want %h", d, g, e);
        end
        n_checks++;
        if (good_cnt !== 16'd1 || bad_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL good_frame_cnt: got %0d/%0d want 1/0",
                     good_cnt, bad_cnt);
        end
        flush();
    endtask

    task automatic test_crc_err();
        bq_t b;
        rec_t g, e;
        int d;
        make_frame(b, mac, 64, 1'b1);
        expect_frame(b);
        send(b, 7, 1);
        settle();
        g = (got_q.size() > 0) ? got_q[$] : '0;
        n_checks++;
        if (g.eop !== 1'b1 || g.status !== 3'b010) begin
            n_fail++;
            $display("FAIL crc_err_status: got eop=%b st=%b want 1/010",
                     g.eop, g.status);
        end
        d = stream_diff(g, e);
        n_checks++;
        if (d !== -1) begin
            n_fail++;
            $display("FAIL crc_err_stream: idx %0d got %h want %h", d, g, e);
        end
        n_checks++;
        if (good_cnt !== 16'(exp_good) || bad_cnt !== 16'(exp_bad)) begin
            n_fail++;
            $display("FAIL crc_err_cnt: got %0d/%0d want %0d/%0d",
                     good_cnt, bad_cnt, exp_good, exp_bad);
        end
        flush();
    endtask

    task automatic test_addr_filter();
        bq_t b;
        rec_t g, e;
        int d;
        logic [2:0] want [3] = '{3'b001, 3'b000, 3'b000};
        for (int k = 0; k < 3; k++) begin
            promisc = (k == 1);
            make_frame(b, (k == 2) ? 48'hFFFFFFFFFFFF : 48'h020000000001,
                       70, 1'b0);
            expect_frame(b);
            send(b, 7, 1);
            settle();
            g = (got_q.size() > 0) ? got_q[$] : '0;
            n_checks++;
            if (g.status !== want[k]) begin
                n_fail++;
                $display("FAIL addr_filter_%0d: got st=%b want %b",
                         k, g.status, want[k]);
            end
            d = stream_diff(g, e);
            n_checks++;
            if (d !== -1) begin
                n_fail++;
                $display("FAIL addr_stream_%0d: idx %0d got %h want %h",
                         k, d, g, e);
            end
            flush();
        end
        promisc = 1'b0;
        n_checks++;
        if (good_cnt !== 16'(exp_good) || bad_cnt !== 16'(exp_bad)) begin
            n_fail++;
            $display("FAIL addr_cnt: got %0d/%0d want %0d/%0d",
                     good_cnt, bad_cnt, exp_good, exp_bad);
        end
    endtask

    task automatic test_length();
        bq_t b;
        rec_t g, e;
        int d;
        make_frame(b, mac, 1600, 1'b0);
        expect_frame(b);
        send(b, 7, 1);
        settle();
        g = (got_q.size() > 0) ? got_q[$] : '0;
        n_checks++;
        if (got_q.size() !== MAX_LEN || g.eop !== 1'b1
            || g.len !== 11'd1518 || g.status[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL oversize: got n=%0d eop=%b len=%0d st=%b want 1518/1/1518/1xx",
                     got_q.size(), g.eop, g.len, g.status);
        end
        d = stream_diff(g, e);
        n_checks++;
        if (d !== -1) begin
            n_fail++;
            $display("FAIL oversize_stream: idx %0d got %h want %h", d, g, e);
        end
        flush();
        make_frame(b, mac, 40, 1'b0);
        expect_frame(b);
        send(b, 7, 1);
        settle();
        g = (got_q.size() > 0) ? got_q[$] : '0;
        n_checks++;
        if (g.status !== 3'b100 || g.len !== 11'd40) begin
            n_fail++;
            $display("FAIL runt: got st=%b len=%0d want 100/40",
                     g.status, g.len);
        end
        n_checks++;
        if (good_cnt !== 16'(exp_good) || bad_cnt !== 16'(exp_bad)) begin
            n_fail++;
            $display("FAIL length_cnt: got %0d/%0d want %0d/%0d",
                     good_cnt, bad_cnt, exp_good, exp_bad);
        end
        flush();
    endtask

    task automatic test_back_to_back();
        bq_t b1, b2;
        bq_t junk;
        rec_t g, e;
        int d;
        int sops;
        int g0;
        g0 = exp_good;
        make_frame(b1, mac, 64, 1'b0);
        make_frame(b2, mac, 80, 1'b0);
        expect_frame(b1);
        expect_frame(b2);
        send(b1, 7, 1);
        send(b2, 7, 1);
        settle();
        junk = '{8'h55, 8'h55, 8'h12, 8'hD5, 8'h0A, 8'h1B, 8'h77};
        foreach (junk[i]) drive(junk[i]);
        settle();
        sops = 0;
        foreach (got_q[i]) sops += int'(got_q[i].sop);
        n_checks++;
        if (sops !== 2 || exp_good - g0 !== 2) begin
            n_fail++;
            $display("FAIL b2b_sop: got %0d sops want 2", sops);
        end
        d = stream_diff(g, e);
        n_checks++;
        if (d !== -1) begin
            n_fail++;
            $display("FAIL b2b_stream: idx %0d got %h want %h", d, g, e);
        end
        n_checks++;
        if (good_cnt !== 16'(exp_good) || bad_cnt !== 16'(exp_bad)) begin
            n_fail++;
            $display("FAIL b2b_cnt: got %0d/%0d want %0d/%0d",
                     good_cnt, bad_cnt, exp_good, exp_bad);
        end
        flush();
    endtask

    task automatic test_one_byte();
        bq_t b;
        rec_t g;
        b = '{8'h42};
        expect_frame(b);
        send(b, 3, 1);
        settle();
        g = (got_q.size() > 0) ? got_q[0] : '0;
        n_checks++;
        if (got_q.size() !== 1 || g.sop !== 1'b1 || g.eop !== 1'b1
            || g.len !== 11'd1 || g.status !== 3'b111) begin
            n_fail++;
            $display("FAIL one_byte: got n=%0d sop=%b eop=%b len=%0d st=%b want 1/1/1/1/111",
                     got_q.size(), g.sop, g.eop, g.len, g.status);
        end
        n_checks++;
        if (bad_cnt !== 16'(exp_bad)) begin
            n_fail++;
            $display("FAIL one_byte_cnt: got %0d want %0d", bad_cnt, exp_bad);
        end
        flush();
    endtask

    task automatic test_reset_mid();
        bq_t b;
        rec_t g, e;
        int d;
        int eops;
        make_frame(b, mac, 64, 1'b0);
        for (int i = 0; i < 7; i++) drive(8'h55);
        drive(8'hD5);
        for (int i = 0; i < 30; i++) drive(b[i]);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rx_out.vl, rx_out.sop, rx_out.eop, rx_out.status,
             rx_out.len, rx_out.data, good_cnt, bad_cnt} !== 57'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got vl=%b eop=%b cnt=%0d/%0d want all 0",
                     rx_out.vl, rx_out.eop, good_cnt, bad_cnt);
        end
        dv = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        eops = 0;
        foreach (got_q[i]) eops += int'(got_q[i].eop);
        n_checks++;
        if (eops !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_eop: got %0d eops want 0", eops);
        end
        flush();
        exp_good = 0;
        exp_bad = 0;
        make_frame(b, mac, 100, 1'b0);
        expect_frame(b);
        send(b, 7, 1);
        settle();
        d = stream_diff(g, e);
        n_checks++;
        if (d !== -1) begin
            n_fail++;
            $display("FAIL reset_mid_next: idx %0d got %h want %h", d, g, e);
        end
        n_checks++;
        if (good_cnt !== 16'd1 || bad_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_cnt: got %0d/%0d want 1/0",
                     good_cnt, bad_cnt);
        end
        flush();
    endtask

    task automatic test_random();
        bq_t b;
        rec_t g, e;
        int d;
        logic [47:0] da;
        for (int batch = 0; batch < 2; batch++) begin
            promisc = batch[0];
            for (int f = 0; f < 12; f++) begin
                case ($urandom_range(0, 2))
                    0: da = mac;
                    1: da = 48'hFFFFFFFFFFFF;
                    default: da = {16'($urandom), 32'($urandom)};
                endcase
                make_frame(b, da, $urandom_range(21, 130),
                           $urandom_range(0, 3) == 0);
                expect_frame(b);
                send(b, $urandom_range(1, 7), $urandom_range(1, 3));
            end
            settle();
            d = stream_diff(g, e);
            n_checks++;
            if (d !== -1) begin
                n_fail++;
                $display("FAIL random_stream_%0d: idx %0d got %h want %h",
                         batch, d, g, e);
            end
            n_checks++;
            if (good_cnt !== 16'(exp_good) || bad_cnt !== 16'(exp_bad)) begin
                n_fail++;
                $display("FAIL random_cnt_%0d: got %0d/%0d want %0d/%0d",
                         batch, good_cnt, bad_cnt, exp_good, exp_bad);
            end
            flush();
        end
        promisc = 1'b0;
    endtask

    initial begin
        build_tab();
        test_reset();
        test_good_frame();
        test_crc_err();
        test_addr_filter();
        test_length();
        test_back_to_back();
        test_one_byte();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
